// File: rtl/soc_system_pll_reconfig_seq_if.sv
// Bundles the request handshake and the Avalon-MM management bus of the PLL
// reconfiguration sequencer. The sequencer is the bus master and the request sink;
// the other side (request source plus reconfig core) connects through the slave modport.
interface soc_system_pll_reconfig_seq_if;

    // Reconfiguration request
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cnt;
    logic [7:0]  req_hi;
    logic [7:0]  req_lo;
    logic        req_odd;
    logic        req_bypass;

    // Avalon-MM management port towards the PLL reconfig core
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        input  req_valid,
        output req_ready,
        input  req_cnt,
        input  req_hi,
        input  req_lo,
        input  req_odd,
        input  req_bypass,
        output mgmt_address,
        output mgmt_write,
        output mgmt_read,
        output mgmt_writedata,
        input  mgmt_readdata,
        input  mgmt_waitrequest
    );

    modport slave (
        output req_valid,
        input  req_ready,
        output req_cnt,
        output req_hi,
        output req_lo,
        output req_odd,
        output req_bypass,
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_read,
        input  mgmt_writedata,
        output mgmt_readdata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/soc_system_pll_reconfig_seq.sv
// PLL C-counter reconfiguration sequencer. Accepts one counter update request,
// programs the reconfig core (mode, counter, start), polls its status until the
// reconfiguration is finished, then waits for a stable PLL lock. Reports the outcome
// with a one-cycle done or error pulse; a global timeout guards status and lock phases.
module soc_system_pll_reconfig_seq #(
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned LOCK_STABLE = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    soc_system_pll_reconfig_seq_if.master        bus,
    input  logic                                 pll_locked,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
);

    localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
    localparam int unsigned LockW = $clog2(LOCK_STABLE + 1);

    localparam logic [TmoW-1:0]  TmoMax   = TmoW'(TIMEOUT);
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_STABLE - 1);

    // Reconfig core register map
    localparam logic [5:0] AddrMode   = 6'h00;
    localparam logic [5:0] AddrStatus = 6'h01;
    localparam logic [5:0] AddrStart  = 6'h02;
    localparam logic [5:0] AddrCCnt   = 6'h05;

    // Mode register value selecting polling (not waitrequest) mode
    localparam logic [31:0] ModePoll = 32'h0000_0001;
    localparam logic [31:0] StartGo  = 32'h0000_0001;

    // Highest legal C-counter index
    localparam logic [3:0] CntMax = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StWrMode,
        StWrCnt,
        StWrStart,
        StRdStatus,
        StWaitLock,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [LockW-1:0] lock_q, lock_d;
    logic             error_q, error_d;
    logic             req_ready_q, req_ready_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       lo_q, lo_d;
    logic             odd_q, odd_d;
    logic             byp_q, byp_d;

    logic             accept;
    logic             xfer_ok;
    logic             tmo_hit;
    logic [TmoW-1:0]  tmo_inc;
    logic             unused_rdata;

    assign accept  = bus.req_valid & req_ready_q;
    // Every bus state holds its strobe, so a transfer completes whenever the stall is low
    assign xfer_ok = ~bus.mgmt_waitrequest;
    assign tmo_hit = (tmo_q == TmoMax);
    // Saturate so the counter cannot wrap back below TIMEOUT
    assign tmo_inc = tmo_hit ? tmo_q : tmo_q + TmoW'(1);

    // Only the status flag of the read data matters
    assign unused_rdata = ^bus.mgmt_readdata[31:1];

    // State, counters and captured request fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            lock_q      <= '0;
            error_q     <= 1'b0;
            req_ready_q <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            odd_q       <= 1'b0;
            byp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            lock_q      <= lock_d;
            error_q     <= error_d;
            req_ready_q <= req_ready_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            odd_q       <= odd_d;
            byp_q       <= byp_d;
        end
    end

    // Next-state, counter and request-capture logic
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        lock_d  = '0;
        error_d = 1'b0;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        odd_d   = odd_q;
        byp_d   = byp_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = bus.req_cnt;
                    hi_d  = bus.req_hi;
                    lo_d  = bus.req_lo;
                    odd_d = bus.req_odd;
                    byp_d = bus.req_bypass;
                    if (bus.req_cnt > CntMax) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = StWrMode;
                    end
                end
            end
            StWrMode: begin
                if (xfer_ok) begin
                    state_d = StWrCnt;
                end
            end
            StWrCnt: begin
                if (xfer_ok) begin
                    state_d = StWrStart;
                end
            end
            StWrStart: begin
                if (xfer_ok) begin
                    state_d = StRdStatus;
                    tmo_d   = '0;
                end
            end
            StRdStatus: begin
                tmo_d = tmo_inc;
                // Timeout wins over a read completing in the same cycle
                if (tmo_hit) begin
                    state_d = StIdle;
                    error_d = 1'b1;
                end else if (xfer_ok && bus.mgmt_readdata[0]) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                tmo_d = tmo_inc;
                if (pll_locked) begin
                    lock_d = lock_q + LockW'(1);
                end
                // Stable lock wins over a simultaneous timeout
                if (pll_locked && (lock_q == LockLast)) begin
                    state_d = StFin;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    error_d = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        req_ready_d = (state_d == StIdle);
    end

    // Bus strobes, address and data decoded from the current state
    always_comb begin
        bus.mgmt_write     = 1'b0;
        bus.mgmt_read      = 1'b0;
        bus.mgmt_address   = '0;
        bus.mgmt_writedata = '0;

        unique case (state_q)
            StWrMode: begin
                bus.mgmt_write     = 1'b1;
                bus.mgmt_address   = AddrMode;
                bus.mgmt_writedata = ModePoll;
            end
            StWrCnt: begin
                bus.mgmt_write     = 1'b1;
                bus.mgmt_address   = AddrCCnt;
                bus.mgmt_writedata = {9'b0, 1'b0, cnt_q, odd_q, byp_q, hi_q, lo_q};
            end
            StWrStart: begin
                bus.mgmt_write     = 1'b1;
                bus.mgmt_address   = AddrStart;
                bus.mgmt_writedata = StartGo;
            end
            StRdStatus: begin
                bus.mgmt_read      = 1'b1;
                bus.mgmt_address   = AddrStatus;
            end
            default: begin
                bus.mgmt_write     = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StFin);
    assign error         = error_q;

    // Protocol sanity: exclusive strobes and exclusive outcome pulses
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(bus.mgmt_read && bus.mgmt_write))
                else $error("read and write strobes asserted together");
            assert (!(done && error))
                else $error("done and error asserted together");
        end
    end

endmodule

// File: tb/tb_soc_system_pll_reconfig_seq.sv
// Randomized self-checking bench for the PLL reconfiguration sequencer. A bus
// responder plays the reconfig core, a monitor records transfers and pulses, and
// a transaction-level model predicts bus traffic and the done/error outcome.
module tb_soc_system_pll_reconfig_seq;

    localparam int unsigned TIMEOUT     = 64;
    localparam int unsigned LOCK_STABLE = 16;

    logic clk;
    logic reset_n;
    logic pll_locked;
    logic busy;
    logic done;
    logic error;

    soc_system_pll_reconfig_seq_if bus ();

    soc_system_pll_reconfig_seq #(
        .TIMEOUT     (TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .pll_locked (pll_locked),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder / monitor state
    int          cyc = 0;
    int          stall_len = 0;
    bit          stall_rand = 0;
    int          zero_reads = 0;
    int          reads_seen = 0;
    int          lock_mode = 0;
    bit          lw_valid = 0;
    int          lw_start = 0;
    bit          lock_hist [256];
    int          done_n = 0;
    int          err_n = 0;
    int          done_cyc = 0;
    int          err_cyc = 0;
    bit          prev_stall = 0;
    logic [39:0] prev_bus = '0;
    bit          in_xfer = 0;
    int          wait_cnt = 0;
    int          cur_stall = 0;

    int          log_cyc [$];
    bit          log_wr [$];
    logic [5:0]  log_addr [$];
    logic [31:0] log_data [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bit lock_pat(input int mode, input int o);
        case (mode)
            0:       return 1'b1;
            1:       return (o != 10);
            2:       return 1'b0;
            default: return ($urandom_range(0, 7) != 0);
        endcase
    endfunction

    // Reconfig-core responder, bus monitor and pll_locked driver
    initial begin
        logic [39:0] cur;
        logic [31:0] rdata;
        bit          v;
        bus.mgmt_waitrequest = 1'b0;
        bus.mgmt_readdata    = '0;
        pll_locked           = 1'b0;
        forever begin
            @(negedge clk);
            check_eq("rd_wr_excl", 64'(bus.mgmt_read & bus.mgmt_write), 64'd0);
            check_eq("done_err_excl", 64'(done & error), 64'd0);
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (error) begin
                err_n++;
                err_cyc = cyc;
            end
            cur = {bus.mgmt_address, bus.mgmt_write, bus.mgmt_read, bus.mgmt_writedata};
            if (prev_stall && busy && reset_n) check_eq("hold_stable", 64'(cur), 64'(prev_bus));
            prev_stall = 1'b0;

            if (!reset_n) begin
                in_xfer              = 1'b0;
                wait_cnt             = 0;
                bus.mgmt_waitrequest = 1'b0;
            end else if (bus.mgmt_write || bus.mgmt_read) begin
                if (!in_xfer) begin
                    in_xfer   = 1'b1;
                    wait_cnt  = 0;
                    cur_stall = stall_rand ? int'($urandom_range(0, 3)) : stall_len;
                end
                if (wait_cnt < cur_stall) begin
                    bus.mgmt_waitrequest = 1'b1;
                    wait_cnt++;
                    prev_stall = 1'b1;
                    prev_bus   = cur;
                end else begin
                    bus.mgmt_waitrequest = 1'b0;
                    in_xfer = 1'b0;
                    log_cyc.push_back(cyc);
                    log_wr.push_back(bus.mgmt_write);
                    log_addr.push_back(bus.mgmt_address);
                    log_data.push_back(bus.mgmt_writedata);
                    if (bus.mgmt_read) begin
                        rdata    = $urandom;
                        rdata[0] = (reads_seen >= zero_reads);
                        bus.mgmt_readdata = rdata;
                        reads_seen++;
                        if (rdata[0]) begin
                            lw_valid = 1'b1;
                            lw_start = cyc + 1;
                        end
                    end
                end
            end else begin
                in_xfer              = 1'b0;
                bus.mgmt_waitrequest = 1'b0;
            end

            if (lw_valid && cyc >= lw_start && cyc - lw_start < 256) begin
                v = lock_pat(lock_mode, cyc - lw_start);
                lock_hist[cyc - lw_start] = v;
                pll_locked = v;
            end else begin
                pll_locked = 1'(($urandom_range(0, 1)));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic prep(input int zr, input int stall, input bit srand, input int lmode);
        zero_reads = zr;
        stall_len  = stall;
        stall_rand = srand;
        lock_mode  = lmode;
        reads_seen = 0;
        lw_valid   = 1'b0;
        for (int i = 0; i < 256; i++) lock_hist[i] = 1'b0;
        log_cyc.delete();
        log_wr.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // Presents one request; returns the cycle in which it was accepted
    task automatic send(input logic [3:0] cnt, input logic [7:0] hi, input logic [7:0] lo,
                        input bit odd, input bit byp, output int acc);
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) break;
            tick();
        end
        check_eq("ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_cnt    = cnt;
        bus.req_hi     = hi;
        bus.req_lo     = lo;
        bus.req_odd    = odd;
        bus.req_bypass = byp;
        acc = cyc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [3:0] cnt, input logic [7:0] hi, input logic [7:0] lo,
                           input bit odd, input bit byp, input int zr, input int stall,
                           input bit srand, input int lmode);
        int          acc;
        int          d0;
        int          e0;
        int          n;
        int          c_start;
        int          ls;
        int          run;
        bit          exp_done;
        int          exp_cyc;
        logic [31:0] pack;
        logic [5:0]  exp_addr;
        prep(zr, stall, srand, lmode);
        d0 = done_n;
        e0 = err_n;
        send(cnt, hi, lo, odd, byp, acc);
        check_eq("busy_after_accept", 64'(busy), 64'd1);
        check_eq("ready_low_busy", 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < 400; i++) begin
            if (done_n != d0 || err_n != e0) break;
            tick();
        end
        check_eq("outcome_seen", 64'(done_n != d0 || err_n != e0), 64'd1);
        repeat (3) tick();
        check_eq("busy_idle", 64'(busy), 64'd0);
        check_eq("ready_idle", 64'(bus.req_ready), 64'd1);

        // Expected traffic: mode, counter, start writes then zr failing polls and one success
        n = log_cyc.size();
        check_eq("n_txn", 64'(n), 64'(zr + 4));
        pack = 32'(cnt) * 32'h4_0000 + 32'(odd) * 32'h2_0000 + 32'(byp) * 32'h1_0000
             + 32'(hi) * 32'h100 + 32'(lo);
        for (int i = 0; i < n && i < zr + 4; i++) begin
            exp_addr = (i == 0) ? 6'h00 : (i == 1) ? 6'h05 : (i == 2) ? 6'h02 : 6'h01;
            check_eq("txn_is_write", 64'(log_wr[i]), 64'(i < 3));
            check_eq("txn_addr", 64'(log_addr[i]), 64'(exp_addr));
            if (i == 1) check_eq("txn_cnt_data", 64'(log_data[i]), 64'(pack));
            else if (i < 3) check_eq("txn_data", 64'(log_data[i]), 64'd1);
        end
        if (stall == 0 && !srand && n > 0) check_eq("first_write_cyc", 64'(log_cyc[0]), 64'(acc + 1));

        // Outcome: the timeout counter starts at zero the cycle after the start write
        // completes; lock-wait begins the cycle after the successful poll.
        if (n == zr + 4) begin
            c_start  = log_cyc[2];
            ls       = log_cyc[n-1] + 1;
            run      = 0;
            exp_done = 1'b0;
            exp_cyc  = -1;
            for (int c = ls; c < ls + 255; c++) begin
                if (lock_hist[c - ls]) run++;
                else run = 0;
                if (run == int'(LOCK_STABLE)) begin
                    exp_done = 1'b1;
                    exp_cyc  = c + 1;
                    break;
                end
                if (c - c_start - 1 >= int'(TIMEOUT)) begin
                    exp_done = 1'b0;
                    exp_cyc  = c + 1;
                    break;
                end
            end
            check_eq("n_done", 64'(done_n - d0), 64'(exp_done));
            check_eq("n_error", 64'(err_n - e0), 64'(!exp_done));
            if (exp_done) check_eq("done_cyc", 64'(done_cyc), 64'(exp_cyc));
            else check_eq("error_cyc", 64'(err_cyc), 64'(exp_cyc));
        end
    endtask

    task automatic run_illegal(input logic [3:0] cnt);
        int acc;
        int d0;
        int e0;
        prep(0, 0, 1'b0, 0);
        d0 = done_n;
        e0 = err_n;
        send(cnt, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), acc);
        check_eq("illegal_err_pulse", 64'(error), 64'd1);
        check_eq("illegal_err_cyc", 64'(cyc), 64'(acc + 1));
        check_eq("illegal_ready", 64'(bus.req_ready), 64'd1);
        check_eq("illegal_busy", 64'(busy), 64'd0);
        tick();
        check_eq("illegal_err_one", 64'(error), 64'd0);
        check_eq("illegal_ready2", 64'(bus.req_ready), 64'd1);
        repeat (4) tick();
        check_eq("illegal_no_txn", 64'(log_cyc.size()), 64'd0);
        check_eq("illegal_n_err", 64'(err_n - e0), 64'd1);
        check_eq("illegal_n_done", 64'(done_n - d0), 64'd0);
    endtask

    task automatic run_reset_mid();
        int acc;
        int d0;
        int e0;
        bit seen;
        prep(0, 3, 1'b0, 0);
        d0 = done_n;
        e0 = err_n;
        send(4'd3, 8'h12, 8'h34, 1'b1, 1'b0, acc);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mgmt_write && bus.mgmt_address == 6'h05) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("reached_wr_cnt", 64'(seen), 64'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_write", 64'(bus.mgmt_write), 64'd0);
        check_eq("rst_read", 64'(bus.mgmt_read), 64'd0);
        check_eq("rst_addr", 64'(bus.mgmt_address), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_eq("rst_ready_after", 64'(bus.req_ready), 64'd1);
        repeat (3) tick();
        check_eq("rst_no_done", 64'(done_n - d0), 64'd0);
        check_eq("rst_no_error", 64'(err_n - e0), 64'd0);
        stall_len = 0;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_cnt    = '0;
        bus.req_hi     = '0;
        bus.req_lo     = '0;
        bus.req_odd    = 1'b0;
        bus.req_bypass = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ready", 64'(bus.req_ready), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_error", 64'(error), 64'd0);
        check_eq("reset_write", 64'(bus.mgmt_write), 64'd0);
        check_eq("reset_read", 64'(bus.mgmt_read), 64'd0);
        check_eq("reset_addr", 64'(bus.mgmt_address), 64'd0);
        check_eq("reset_wdata", 64'(bus.mgmt_writedata), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("ready_first_edge", 64'(bus.req_ready), 64'd1);

        // Basic sequence: counter 2, hi/lo 4, no stalls, immediate status, steady lock
        run_req(4'd2, 8'd4, 8'd4, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        // Every transfer stalled three cycles
        run_req(4'd2, 8'd4, 8'd4, 1'b0, 1'b0, 0, 3, 1'b0, 0);
        // Illegal counter indices
        run_illegal(4'd9);
        run_illegal(4'(($urandom_range(10, 15))));
        // Five busy status polls before success
        run_req(4'd7, 8'hA5, 8'h3C, 1'b1, 1'b1, 5, 0, 1'b0, 0);
        // Lock drops once during the wait, then lock never arrives (timeout)
        run_req(4'd0, 8'h01, 8'hFF, 1'b0, 1'b1, 0, 0, 1'b0, 1);
        run_req(4'd8, 8'h80, 8'h01, 1'b1, 1'b0, 1, 1, 1'b0, 2);
        // Reset in the middle of a stalled counter write, then recovery
        run_reset_mid();
        run_req(4'd5, 8'h22, 8'h33, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        // Randomized requests, stalls, poll counts and lock behaviour
        for (int k = 0; k < 8; k++) begin
            run_req(4'(($urandom_range(0, 8))), 8'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), int'($urandom_range(0, 4)), 0, 1'b1,
                    ($urandom_range(0, 1) == 0) ? 0 : 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
